// File: rtl/johnson_counter_param.sv
// Parametrised Johnson/ring shift counter with direction, enable, parallel load,
// phase decode, wrap pulse and illegal-state flag.
// Optional build macro: JOHNSON_SELF_CORRECT_EN (illegal states/loads recover to the seed).
module johnson_counter_param #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned PW    = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic [PW-1:0]    phase,
   output logic             wrap,
   output logic             illegal,
   output logic             fixed
);

   // Membership of v in the sequence of mode m (0 = Johnson, 1 = ring)
   function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
      logic [WIDTH-1:0] nv;
      logic             ok;
      nv = ~v;
      if (m) begin
         ok = (v != '0) && ((v & (v - WIDTH'(1))) == '0);
      end else begin
         // ones anchored at LSB (v = 2^k-1) or at MSB (~v = 2^k-1)
         ok = ((v & (v + WIDTH'(1))) == '0) || ((nv & (nv + WIDTH'(1))) == '0);
      end
      return ok;
   endfunction

   // Starting state of each mode
   function automatic logic [WIDTH-1:0] seed_of(input logic m);
      return m ? WIDTH'(1) : '0;
   endfunction

   // Step index of v within the sequence of mode m; illegal states decode to 0
   function automatic logic [PW-1:0] phase_of(input logic [WIDTH-1:0] v, input logic m);
      logic [PW-1:0] p;
      p = '0;
      if (is_legal(v, m)) begin
         if (m) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
               if (v[i]) p = PW'(i);
            end
         end else if (!v[WIDTH-1]) begin
            p = PW'($countones(v));
         end else begin
            p = PW'(WIDTH) + PW'(int'(WIDTH) - $countones(v));
         end
      end
      return p;
   endfunction

   // One shift step of mode m in direction d (0 = toward MSB)
   function automatic logic [WIDTH-1:0] step_of(input logic [WIDTH-1:0] v,
                                                input logic m, input logic d);
      logic [WIDTH-1:0] n;
      if (!d) n = {v[WIDTH-2:0], (m ? v[WIDTH-1] : ~v[WIDTH-1])};
      else    n = {(m ? v[0] : ~v[0]), v[WIDTH-1:1]};
      return n;
   endfunction

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] qb_q;
   logic             mode_q, mode_d;
   logic             wrap_q, wrap_d;
   logic             fixed_q, fixed_d;
   logic             legal_c;
   logic [PW-1:0]    phase_c;
   logic [PW-1:0]    last_c;

   // Decode of the current state against the registered mode
   always_comb begin
      legal_c = is_legal(q_q, mode_q);
      phase_c = phase_of(q_q, mode_q);
      last_c  = mode_q ? PW'(WIDTH - 1) : PW'(2*WIDTH - 1);
   end

   // Next state: mode change > load > self-correct > advance > hold
   always_comb begin
      mode_d  = mode_q;
      q_d     = q_q;
      wrap_d  = 1'b0;
      fixed_d = 1'b0;
      if (mode != mode_q) begin
         mode_d = mode;
         q_d    = seed_of(mode);
      end else if (load) begin
         q_d = load_val;
`ifdef JOHNSON_SELF_CORRECT_EN
         if (!is_legal(load_val, mode_q)) begin
            q_d     = seed_of(mode_q);
            fixed_d = 1'b1;
         end
`endif
      end
`ifdef JOHNSON_SELF_CORRECT_EN
      else if (!legal_c) begin
         q_d     = seed_of(mode_q);
         fixed_d = 1'b1;
      end
`endif
      else if (en) begin
         q_d    = step_of(q_q, mode_q, dir);
         wrap_d = legal_c && (dir ? (phase_c == '0) : (phase_c == last_c));
      end
   end

   // State registers with synchronous active-low clear to the seed of the mode input
   always_ff @(posedge clk) begin
      if (!clr) begin
         mode_q  <= mode;
         q_q     <= seed_of(mode);
         qb_q    <= ~seed_of(mode);
         wrap_q  <= 1'b0;
         fixed_q <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         q_q     <= q_d;
         qb_q    <= ~q_d;
         wrap_q  <= wrap_d;
         fixed_q <= fixed_d;
      end
   end

   assign q       = q_q;
   assign qb      = qb_q;
   assign phase   = phase_c;
   assign wrap    = wrap_q;
   assign illegal = ~legal_c;
   assign fixed   = fixed_q;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed testbench for johnson_counter_param at WIDTH=4.
module tb_johnson_counter_param;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned PW    = $clog2(2*WIDTH);

   logic             clk;
   logic             clr;
   logic             en;
   logic             dir;
   logic             mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic [PW-1:0]    phase;
   logic             wrap;
   logic             illegal;
   logic             fixed;

   int errors = 0;
   int checks = 0;

   johnson_counter_param #(.WIDTH(WIDTH)) dut (
      .clk(clk), .clr(clr), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_val(load_val), .q(q), .qb(qb), .phase(phase), .wrap(wrap),
      .illegal(illegal), .fixed(fixed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle before sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b0; en = 1'b1; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
      step();
      checks++; if (q !== 4'b0000) begin errors++; $display("FAIL reset_q got %b exp 0000", q); end
      checks++; if (qb !== 4'b1111) begin errors++; $display("FAIL reset_qb got %b exp 1111", qb); end
      checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
      checks++; if (wrap !== 1'b0 || fixed !== 1'b0 || illegal !== 1'b0) begin
         errors++; $display("FAIL reset_flags got wrap=%b fixed=%b illegal=%b exp 0 0 0", wrap, fixed, illegal);
      end
      clr = 1'b1;
   endtask

   task automatic test_johnson_up();
      logic [3:0] exp_q [9];
      logic [2:0] exp_p [9];
      logic       exp_w [9];
      exp_q = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
      exp_p = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      en = 1'b1; dir = 1'b0;
      for (int i = 0; i < 9; i++) begin
         step();
         checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL jup_q[%0d] got %b exp %b", i, q, exp_q[i]); end
         checks++; if (qb !== ~exp_q[i]) begin errors++; $display("FAIL jup_qb[%0d] got %b exp %b", i, qb, ~exp_q[i]); end
         checks++; if (phase !== exp_p[i]) begin errors++; $display("FAIL jup_phase[%0d] got %0d exp %0d", i, phase, exp_p[i]); end
         checks++; if (wrap !== exp_w[i]) begin errors++; $display("FAIL jup_wrap[%0d] got %b exp %b", i, wrap, exp_w[i]); end
      end
   endtask

   task automatic test_johnson_down();
      logic [3:0] exp_q [4];
      logic [2:0] exp_p [4];
      logic       exp_w [4];
      exp_q = '{4'h3, 4'h1, 4'h0, 4'h8};
      exp_p = '{3'd2, 3'd1, 3'd0, 3'd7};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b1};
      // bring q from 0001 up to 0111
      en = 1'b1; dir = 1'b0;
      step(); step();
      checks++; if (q !== 4'b0111) begin errors++; $display("FAIL jdn_start got %b exp 0111", q); end
      dir = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL jdn_q[%0d] got %b exp %b", i, q, exp_q[i]); end
         checks++; if (phase !== exp_p[i]) begin errors++; $display("FAIL jdn_phase[%0d] got %0d exp %0d", i, phase, exp_p[i]); end
         checks++; if (wrap !== exp_w[i]) begin errors++; $display("FAIL jdn_wrap[%0d] got %b exp %b", i, wrap, exp_w[i]); end
      end
   endtask

   task automatic test_mode_change();
      logic [3:0] exp_q [4];
      logic [2:0] exp_p [4];
      logic       exp_w [4];
      exp_q = '{4'h2, 4'h4, 4'h8, 4'h1};
      exp_p = '{3'd1, 3'd2, 3'd3, 3'd0};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b1};
      // 1000 down -> 1100
      en = 1'b1; dir = 1'b1;
      step();
      checks++; if (q !== 4'b1100 || phase !== 3'd6) begin
         errors++; $display("FAIL mode_pre got q=%b phase=%0d exp 1100 6", q, phase);
      end
      mode = 1'b1; dir = 1'b0;
      step();
      checks++; if (q !== 4'b0001) begin errors++; $display("FAIL mode_seed got %b exp 0001", q); end
      checks++; if (wrap !== 1'b0 || illegal !== 1'b0 || phase !== 3'd0) begin
         errors++; $display("FAIL mode_flags got wrap=%b illegal=%b phase=%0d exp 0 0 0", wrap, illegal, phase);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL ring_q[%0d] got %b exp %b", i, q, exp_q[i]); end
         checks++; if (phase !== exp_p[i]) begin errors++; $display("FAIL ring_phase[%0d] got %0d exp %0d", i, phase, exp_p[i]); end
         checks++; if (wrap !== exp_w[i]) begin errors++; $display("FAIL ring_wrap[%0d] got %b exp %b", i, wrap, exp_w[i]); end
      end
      // ring down from 0001 wraps to 1000
      dir = 1'b1;
      step();
      checks++; if (q !== 4'b1000 || phase !== 3'd3 || wrap !== 1'b1) begin
         errors++; $display("FAIL ring_down got q=%b phase=%0d wrap=%b exp 1000 3 1", q, phase, wrap);
      end
   endtask

   task automatic test_illegal_load();
      mode = 1'b0; en = 1'b1; dir = 1'b0;
      step();
      checks++; if (q !== 4'b0000) begin errors++; $display("FAIL back_to_johnson got %b exp 0000", q); end
      load = 1'b1; load_val = 4'b0101; en = 1'b0;
      step();
      load = 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
      checks++; if (q !== 4'b0000 || fixed !== 1'b1 || illegal !== 1'b0) begin
         errors++; $display("FAIL illegal_load got q=%b fixed=%b illegal=%b exp 0000 1 0", q, fixed, illegal);
      end
      step();
      checks++; if (q !== 4'b0000 || fixed !== 1'b0) begin
         errors++; $display("FAIL illegal_after got q=%b fixed=%b exp 0000 0", q, fixed);
      end
`else
      checks++; if (q !== 4'b0101 || illegal !== 1'b1 || phase !== 3'd0 || fixed !== 1'b0) begin
         errors++; $display("FAIL illegal_load got q=%b illegal=%b phase=%0d fixed=%b exp 0101 1 0 0", q, illegal, phase, fixed);
      end
      step();
      checks++; if (q !== 4'b0101 || illegal !== 1'b1) begin
         errors++; $display("FAIL illegal_hold got q=%b illegal=%b exp 0101 1", q, illegal);
      end
`endif
   endtask

   task automatic test_clr_mid();
      load = 1'b1; load_val = 4'b1110; en = 1'b0;
      step();
      load = 1'b0;
      checks++; if (q !== 4'b1110 || phase !== 3'd5) begin
         errors++; $display("FAIL clr_pre got q=%b phase=%0d exp 1110 5", q, phase);
      end
      en = 1'b1; clr = 1'b0;
      step();
      clr = 1'b1;
      checks++; if (q !== 4'b0000 || qb !== 4'b1111 || wrap !== 1'b0) begin
         errors++; $display("FAIL clr_mid got q=%b qb=%b wrap=%b exp 0000 1111 0", q, qb, wrap);
      end
      en = 1'b0;
      step(); step();
      checks++; if (q !== 4'b0000) begin errors++; $display("FAIL clr_hold got %b exp 0000", q); end
   endtask

   task automatic test_back_to_back();
      load = 1'b1; en = 1'b1; load_val = 4'b0011; dir = 1'b0;
      step();
      load = 1'b0;
      checks++; if (q !== 4'b0011 || phase !== 3'd2) begin
         errors++; $display("FAIL load_prio got q=%b phase=%0d exp 0011 2", q, phase);
      end
      step();
      checks++; if (q !== 4'b0111 || phase !== 3'd3 || wrap !== 1'b0) begin
         errors++; $display("FAIL load_next got q=%b phase=%0d wrap=%b exp 0111 3 0", q, phase, wrap);
      end
   endtask

   initial begin
      test_reset();
      test_johnson_up();
      test_johnson_down();
      test_mode_change();
      test_illegal_load();
      test_clr_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/johnson_counter_param.md
Name: johnson_counter_param

Overview:
- Parametrised successor to the fixed 4-bit Johnson counter: WIDTH-bit shift counter selectable at run time between Johnson (twisted-ring, 2*WIDTH states) and ring (one-hot, WIDTH states) sequencing.
- Adds up/down direction, count enable, parallel load, phase index decode, a wrap pulse and illegal-state detection.
- Used as a phase/sequence generator for stepper-style and multiphase timing logic in the lab designs.

Parameters:
- WIDTH, 4, number of state flops; legal range 2..16.
- PW, $clog2(2*WIDTH), width of phase output (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-low reset; clr=0 at a rising clk edge resets the block.
- en  input  1  count enable; advance one step per clk when high.
- dir  input  1  0 = up (shift toward MSB), 1 = down (shift toward LSB).
- mode  input  1  0 = Johnson, 1 = ring.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- q  output  WIDTH  counter state (registered).
- qb  output  WIDTH  bitwise complement of q.
- phase  output  PW  step index of q within the current mode sequence.
- wrap  output  1  one-cycle pulse after sequence wrap-around (registered).
- illegal  output  1  q is not a member of the current mode's sequence.
- fixed  output  1  one-cycle pulse: an illegal state/load was corrected (SELF_CORRECT_EN only; else tied 0).

Behaviour:
- Priority per clk edge: clr=0 > mode change > load > en > hold.
- Reset (clr=0): q = seed of the mode input value (Johnson seed all-zeros; ring seed 0...01); mode_q = mode; wrap=0; fixed=0. qb = ~q, so qb resets to all-ones (Johnson).
- Mode change: internal mode_q holds the registered mode. If mode != mode_q at an edge:
  - mode_q <= mode; q <= new mode's seed; wrap <= 0.
  - load and en are ignored that cycle.
- Load: q <= load_val. The load_val legality check is against mode_q. en is ignored in a load cycle.
- Johnson up: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - WIDTH=4 from 0000: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
- Johnson down: q <= {~q[0], q[WIDTH-1:1]}; exact reverse of the up sequence.
- Ring up: q <= {q[WIDTH-2:0], q[WIDTH-1]}. Ring down: q <= {q[0], q[WIDTH-1:1]}.
- en=0 and no load/mode change: q holds.
- phase is a combinational decode of q, zero latency:
  - Johnson, q[WIDTH-1]=0: phase = count of ones.
  - Johnson, q[WIDTH-1]=1: phase = WIDTH + count of zeros.
  - Ring: phase = index of the set bit.
  - Illegal q: phase = 0.
- Legal Johnson state: a contiguous run of ones anchored at the LSB, or a contiguous run of ones anchored at the MSB.
- Legal ring state: exactly one bit set.
- illegal is combinational from q and mode_q.
- wrap is registered. It is 1 in the cycle following an en-advance where phase went last->0 (up) or 0->last (down); otherwise 0. Load and mode-change cycles never set wrap.
- dir may change on any cycle; the next advance uses the new dir, with no glitch or skipped state.
- clr=0 mid-sequence overrides everything on that edge; the counter restarts from the seed on the next en cycle.

Optional Feature:
- Macro: JOHNSON_SELF_CORRECT_EN.
- Defined:
  - An en-advance or hold from an illegal q loads the seed instead, and fixed pulses for 1 cycle.
  - A load of an illegal load_val loads the seed instead, and fixed pulses.
  - Recovery from any corrupted state takes at most 1 clk.
- Undefined:
  - Illegal values load and shift as-is; illegal flags them.
  - Johnson lock-up cycles (e.g. 0101 for WIDTH=4) persist.
  - fixed is tied 0.

Test Plan:
- WIDTH=4, clr=0 one edge, then mode=0 dir=0 en=1 for 9 clks -> q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; phase 1..7, 0, 1; wrap high exactly once, the cycle after q=0000 is reached; qb = ~q throughout.
- From q=0111, set dir=1 for 4 clks -> q = 0011, 0001, 0000, 1000; wrap pulses once after 0000->1000; phase 7.
- Switch mode=1 while q=1100 -> next edge q=0001 with en ignored; then 4 up clks -> 0010, 0100, 1000, 0001; wrap once.
- mode=0, load=1, load_val=0101:
  - Macro off: q=0101, illegal=1, phase=0.
  - Macro on: q=0000, fixed=1 for one cycle, illegal=0.
- Counting at q=1110 with en=1, assert clr=0 one edge -> q=0000, qb=1111, wrap=0; with en=0 afterwards q holds 0000.
- Simultaneous load=1 and en=1 with load_val=0011 -> q=0011, with no advance that cycle; the next en edge gives 0111.
